hbm_burst_master: RTL

- AXI-MM burst initiator that drives the HBM port, either the real HBM channel or `emulate_HBM` in simulation.
- Accepts one read or write command at a time on a valid/ready command channel.
- Read: issues AR, then streams R beats out on a valid/ready stream.
- Write: issues AW, consumes a valid/ready input stream as W beats, then collects B.
- Sits between CGRA load/store units and the memory port.

---
 rtl/hbm_burst_master_pkg.sv | 22 ++
 rtl/hbm_burst_master_if.sv | 88 ++++++++
 rtl/hbm_burst_master.sv | 137 +++++++++++++
 3 files changed

// File: rtl/hbm_burst_master_pkg.sv
// hbm_burst_master shared types and widths.
// Beat/address widths and the burst FSM state encoding.
package hbm_burst_master_pkg;

    localparam int phit_size    = 512;
    localparam int dwidth_aximm = 64;
    localparam int strb_w       = phit_size / 8;

    // Beats are phit-aligned, so the byte offset inside a beat is cleared.
    localparam logic [dwidth_aximm-1:0] addr_mask =
        ~(dwidth_aximm'(strb_w - 1));

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR,
        WR_DATA,
        WR_RESP
    } hbm_mst_state_t;

endpackage

// File: rtl/hbm_burst_master_if.sv
// hbm_burst_master bus bundle.
// Command, user streams and the AXI-MM port toward HBM.
interface hbm_burst_master_if;
    import hbm_burst_master_pkg::*;

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [dwidth_aximm-1:0] cmd_addr;
    logic [7:0]              cmd_len;

    logic [phit_size-1:0]    m_data;
    logic                    m_valid;
    logic                    m_last;
    logic                    m_ready;

    logic [phit_size-1:0]    s_data;
    logic                    s_valid;
    logic                    s_ready;

    logic                    done;
    logic                    err;

    logic [dwidth_aximm-1:0] axi_araddr;
    logic [7:0]              axi_arlen;
    logic                    axi_arvalid;
    logic                    axi_arready;

    logic [phit_size-1:0]    axi_rdata;
    logic                    axi_rlast;
    logic                    axi_rvalid;
    logic                    axi_rready;

    logic [dwidth_aximm-1:0] axi_awaddr;
    logic [7:0]              axi_awlen;
    logic                    axi_awvalid;
    logic                    axi_awready;

    logic [phit_size-1:0]    axi_wdata;
    logic                    axi_wlast;
    logic [strb_w-1:0]       axi_wstrb;
    logic                    axi_wvalid;
    logic                    axi_wready;

    logic                    axi_bvalid;
    logic                    axi_bready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        output cmd_ready,
        output m_data, m_valid, m_last,
        input  m_ready,
        input  s_data, s_valid,
        output s_ready,
        output done, err,
        output axi_araddr, axi_arlen, axi_arvalid,
        input  axi_arready,
        input  axi_rdata, axi_rlast, axi_rvalid,
        output axi_rready,
        output axi_awaddr, axi_awlen, axi_awvalid,
        input  axi_awready,
        output axi_wdata, axi_wlast, axi_wstrb, axi_wvalid,
        input  axi_wready,
        input  axi_bvalid,
        output axi_bready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  cmd_ready,
        input  m_data, m_valid, m_last,
        output m_ready,
        output s_data, s_valid,
        input  s_ready,
        input  done, err,
        input  axi_araddr, axi_arlen, axi_arvalid,
        output axi_arready,
        output axi_rdata, axi_rlast, axi_rvalid,
        input  axi_rready,
        input  axi_awaddr, axi_awlen, axi_awvalid,
        output axi_awready,
        input  axi_wdata, axi_wlast, axi_wstrb, axi_wvalid,
        output axi_wready,
        output axi_bvalid,
        input  axi_bready
    );

endinterface

// File: rtl/hbm_burst_master.sv
// hbm_burst_master: one-at-a-time AXI-MM burst initiator.
// Reads stream R to m_*, writes stream s_* to W, then collect B.
module hbm_burst_master
    import hbm_burst_master_pkg::*;
(
    input  logic               ap_clk,
    input  logic               ap_rst,
    hbm_burst_master_if.master bus
);

    hbm_mst_state_t          state_q;
    logic [7:0]              beat_cnt_q;
    logic [7:0]              len_q;
    logic [dwidth_aximm-1:0] addr_q;
    logic                    cmd_ready_q;
    logic                    arvalid_q;
    logic                    awvalid_q;
    logic                    bready_q;
    logic                    done_q;
    logic                    err_q;

    logic in_rd;
    logic in_wr;
    logic last_beat;
    logic r_hs;
    logic w_hs;

    assign in_rd     = (state_q == RD_DATA);
    assign in_wr     = (state_q == WR_DATA);
    assign last_beat = (beat_cnt_q == len_q);
    assign r_hs      = in_rd & bus.axi_rvalid & bus.m_ready;
    assign w_hs      = in_wr & bus.s_valid & bus.axi_wready;

    // Burst FSM with registered control outputs.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            len_q       <= '0;
            addr_q      <= '0;
            cmd_ready_q <= 1'b0;
            arvalid_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        addr_q      <= bus.cmd_addr & addr_mask;
                        len_q       <= bus.cmd_len;
                        beat_cnt_q  <= '0;
                        cmd_ready_q <= 1'b0;
                        if (bus.cmd_write) begin
                            awvalid_q <= 1'b1;
                            state_q   <= WR_ADDR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD_ADDR;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                RD_ADDR: begin
                    if (bus.axi_arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (r_hs) begin
                        beat_cnt_q <= beat_cnt_q + 8'd1;
                        if (bus.axi_rlast != last_beat) begin
                            err_q <= 1'b1;
                        end
                        // Count decides the end; rlast only flags errors.
                        if (last_beat) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                WR_ADDR: begin
                    if (bus.axi_awready) begin
                        awvalid_q <= 1'b0;
                        state_q   <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        beat_cnt_q <= beat_cnt_q + 8'd1;
                        if (last_beat) begin
                            bready_q <= 1'b1;
                            state_q  <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (bus.axi_bvalid) begin
                        bready_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;

    assign bus.axi_araddr  = addr_q;
    assign bus.axi_arlen   = len_q;
    assign bus.axi_arvalid = arvalid_q;
    assign bus.axi_awaddr  = addr_q;
    assign bus.axi_awlen   = len_q;
    assign bus.axi_awvalid = awvalid_q;
    assign bus.axi_bready  = bready_q;

    assign bus.m_data      = in_rd ? bus.axi_rdata : '0;
    assign bus.m_valid     = in_rd & bus.axi_rvalid;
    assign bus.m_last      = in_rd & last_beat;
    assign bus.axi_rready  = in_rd & bus.m_ready;

    assign bus.axi_wdata   = in_wr ? bus.s_data : '0;
    assign bus.axi_wvalid  = in_wr & bus.s_valid;
    assign bus.axi_wlast   = in_wr & last_beat;
    assign bus.axi_wstrb   = in_wr ? '1 : '0;
    assign bus.s_ready     = in_wr & bus.axi_wready;

endmodule
